decode_ctrl_seq: RTL and testbench

DECODE_CTRL_SEQ -- requirements
Module: decode_ctrl_seq

---
 rtl/decode_ctrl_seq_pkg.sv | 47 ++++
 rtl/ctrl_decode.sv | 86 ++++++++
 rtl/decode_ctrl_seq.sv | 134 +++++++++++++
 tb/tb_decode_ctrl_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_seq_pkg.sv
// Shared encodings for the ID-stage control decoder: opcodes, EXE commands,
// branch conditions and the flag bundle that travels to the ID/EXE register.
package decode_ctrl_seq_pkg;

  localparam int OP_CODE_LEN_DEF = 4;
  localparam int EXE_CMD_LEN_DEF = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_COMP = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;

  localparam logic [3:0] EXE_NO_OPERATION = 4'd0;
  localparam logic [3:0] EXE_ADD          = 4'd1;
  localparam logic [3:0] EXE_SUB          = 4'd2;
  localparam logic [3:0] EXE_AND          = 4'd3;
  localparam logic [3:0] EXE_SLL          = 4'd4;
  localparam logic [3:0] EXE_MUL          = 4'd5;

  localparam logic [1:0] COND_NONE = 2'd0;
  localparam logic [1:0] COND_JUMP = 2'd1;
  localparam logic [1:0] COND_BNE  = 2'd2;

  typedef struct packed {
    logic [1:0] branch_command;
    logic       branch_en;
    logic       is_imm;
    logic       st_or_bne;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       mov_en;
    logic       is_comp;
    logic       is_mul;
  } ctrl_flags_t;

  localparam ctrl_flags_t FLAGS_NONE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure opcode-to-control-bundle lookup; unknown opcodes report legal = 0
// and return an all-zero bundle.
module ctrl_decode
  import decode_ctrl_seq_pkg::*;
#(
  parameter int OP_CODE_LEN = OP_CODE_LEN_DEF,
  parameter int EXE_CMD_LEN = EXE_CMD_LEN_DEF
) (
  input  logic [OP_CODE_LEN-1:0] op_code,
  output logic [EXE_CMD_LEN-1:0] exe_cmd,
  output ctrl_flags_t            flags,
  output logic                   legal
);

  always_comb begin
    exe_cmd = EXE_CMD_LEN'(EXE_NO_OPERATION);
    flags   = FLAGS_NONE;
    legal   = 1'b1;
    case (op_code)
      OP_CODE_LEN'(OP_ADD): begin
        exe_cmd     = EXE_CMD_LEN'(EXE_ADD);
        flags.wb_en = 1'b1;
      end
      OP_CODE_LEN'(OP_SUB): begin
        exe_cmd     = EXE_CMD_LEN'(EXE_SUB);
        flags.wb_en = 1'b1;
      end
      OP_CODE_LEN'(OP_AND): begin
        exe_cmd     = EXE_CMD_LEN'(EXE_AND);
        flags.wb_en = 1'b1;
      end
      OP_CODE_LEN'(OP_SLL): begin
        exe_cmd     = EXE_CMD_LEN'(EXE_SLL);
        flags.wb_en = 1'b1;
      end
      OP_CODE_LEN'(OP_MUL): begin
        exe_cmd      = EXE_CMD_LEN'(EXE_MUL);
        flags.wb_en  = 1'b1;
        flags.is_mul = 1'b1;
      end
      // COMP reuses the subtractor; only the flags differ from SUB
      OP_CODE_LEN'(OP_COMP): begin
        exe_cmd       = EXE_CMD_LEN'(EXE_SUB);
        flags.wb_en   = 1'b1;
        flags.is_comp = 1'b1;
      end
      OP_CODE_LEN'(OP_ADDI): begin
        exe_cmd      = EXE_CMD_LEN'(EXE_ADD);
        flags.wb_en  = 1'b1;
        flags.is_imm = 1'b1;
      end
      OP_CODE_LEN'(OP_MOV): begin
        flags.is_imm = 1'b1;
        flags.mov_en = 1'b1;
      end
      OP_CODE_LEN'(OP_LD): begin
        exe_cmd         = EXE_CMD_LEN'(EXE_ADD);
        flags.wb_en     = 1'b1;
        flags.is_imm    = 1'b1;
        flags.st_or_bne = 1'b1;
        flags.mem_r_en  = 1'b1;
      end
      OP_CODE_LEN'(OP_ST): begin
        exe_cmd         = EXE_CMD_LEN'(EXE_ADD);
        flags.is_imm    = 1'b1;
        flags.st_or_bne = 1'b1;
        flags.mem_w_en  = 1'b1;
      end
      OP_CODE_LEN'(OP_BNE): begin
        flags.is_imm         = 1'b1;
        flags.branch_command = COND_BNE;
        flags.branch_en      = 1'b1;
        flags.st_or_bne      = 1'b1;
      end
      OP_CODE_LEN'(OP_JMP): begin
        flags.is_imm         = 1'b1;
        flags.branch_command = COND_JUMP;
        flags.branch_en      = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_seq.sv
// ID-stage control sequencer: registers the decoded bundle and inserts bubbles
// for hazards, multi-cycle multiplies and post-branch flushes.
module decode_ctrl_seq
  import decode_ctrl_seq_pkg::*;
#(
  parameter int OP_CODE_LEN = OP_CODE_LEN_DEF,
  parameter int EXE_CMD_LEN = EXE_CMD_LEN_DEF,
  parameter int MUL_CYCLES  = 4,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   op_valid,
  input  logic                   hazard_detected,
  input  logic                   branch_taken,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [1:0]             Branch_command,
  output logic                   branchEn,
  output logic                   Is_Imm,
  output logic                   ST_or_BNE,
  output logic                   WB_EN,
  output logic                   MEM_R_EN,
  output logic                   MEM_W_EN,
  output logic                   MOV_EN,
  output logic                   Is_Comp,
  output logic                   Is_Mul,
  output logic                   ctrl_valid,
  output logic                   stall_req,
  output logic                   illegal_op
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

  state_t                 state;
  logic [3:0]             mul_cnt;
  logic [1:0]             flush_cnt;
  ctrl_flags_t            flags_q;
  logic [EXE_CMD_LEN-1:0] dec_cmd;
  ctrl_flags_t            dec_flags;
  logic                   dec_legal;

  ctrl_decode #(
    .OP_CODE_LEN(OP_CODE_LEN),
    .EXE_CMD_LEN(EXE_CMD_LEN)
  ) u_ctrl_decode (
    .op_code(opCode),
    .exe_cmd(dec_cmd),
    .flags  (dec_flags),
    .legal  (dec_legal)
  );

  // Every path starts from a bubble; only an accepted legal opcode overrides it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      mul_cnt    <= 4'd0;
      flush_cnt  <= 2'd0;
      EXE_CMD    <= EXE_CMD_LEN'(EXE_NO_OPERATION);
      flags_q    <= FLAGS_NONE;
      ctrl_valid <= 1'b0;
      stall_req  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      EXE_CMD    <= EXE_CMD_LEN'(EXE_NO_OPERATION);
      flags_q    <= FLAGS_NONE;
      ctrl_valid <= 1'b0;
      stall_req  <= 1'b0;
      illegal_op <= 1'b0;
      if (branch_taken) begin
        mul_cnt   <= 4'd0;
        flush_cnt <= FLUSH_LOAD;
        state     <= (FLUSH_DEPTH > 1) ? FLUSH : RUN;
      end else begin
        case (state)
          MUL_BUSY: begin
            if (mul_cnt <= 4'd1) begin
              mul_cnt <= 4'd0;
              state   <= RUN;
            end else begin
              mul_cnt   <= mul_cnt - 4'd1;
              stall_req <= 1'b1;
            end
          end
          FLUSH: begin
            if (flush_cnt <= 2'd1) begin
              flush_cnt <= 2'd0;
              state     <= RUN;
            end else begin
              flush_cnt <= flush_cnt - 2'd1;
            end
          end
          default: begin
            state <= RUN;
            if (op_valid && !hazard_detected) begin
              if (!dec_legal) begin
                illegal_op <= 1'b1;
              end else begin
                EXE_CMD    <= dec_cmd;
                flags_q    <= dec_flags;
                ctrl_valid <= 1'b1;
                // the multiply bundle goes out now; stall covers the remaining cycles
                if (dec_flags.is_mul && (MUL_CYCLES > 1)) begin
                  state     <= MUL_BUSY;
                  mul_cnt   <= MUL_LOAD;
                  stall_req <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign Branch_command = flags_q.branch_command;
  assign branchEn       = flags_q.branch_en;
  assign Is_Imm         = flags_q.is_imm;
  assign ST_or_BNE      = flags_q.st_or_bne;
  assign WB_EN          = flags_q.wb_en;
  assign MEM_R_EN       = flags_q.mem_r_en;
  assign MEM_W_EN       = flags_q.mem_w_en;
  assign MOV_EN         = flags_q.mov_en;
  assign Is_Comp        = flags_q.is_comp;
  assign Is_Mul         = flags_q.is_mul;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Scoreboard bench for decode_ctrl_seq: the driver pushes reference-model
// expectations, a separate monitor pops and compares one per clock.
module tb_decode_ctrl_seq;
  import decode_ctrl_seq_pkg::*;

  localparam int MUL_CYCLES  = 4;
  localparam int FLUSH_DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opCode = 4'd0;
  logic       op_valid = 1'b0;
  logic       hazard_detected = 1'b0;
  logic       branch_taken = 1'b0;
  logic [3:0] EXE_CMD;
  logic [1:0] Branch_command;
  logic       branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN;
  logic       MOV_EN, Is_Comp, Is_Mul, ctrl_valid, stall_req, illegal_op;

  always #5 clk = ~clk;

  decode_ctrl_seq #(
    .OP_CODE_LEN(4),
    .EXE_CMD_LEN(4),
    .MUL_CYCLES (MUL_CYCLES),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .op_valid(op_valid),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .EXE_CMD(EXE_CMD), .Branch_command(Branch_command), .branchEn(branchEn),
    .Is_Imm(Is_Imm), .ST_or_BNE(ST_or_BNE), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .MOV_EN(MOV_EN), .Is_Comp(Is_Comp), .Is_Mul(Is_Mul),
    .ctrl_valid(ctrl_valid), .stall_req(stall_req), .illegal_op(illegal_op)
  );

  // Bundle layout: cmd[17:14] br[13:12] bEn imm st wb mr mw mov cmp mul valid stall ill
  localparam logic [17:0] BUBBLE = 18'd0;

  logic [17:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int busy_left = 0;   // cycles the multiply still occupies the decoder
  int flush_left = 0;  // bubbles still owed after a taken branch

  function automatic logic [17:0] actual();
    return {EXE_CMD, Branch_command, branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN,
            MEM_W_EN, MOV_EN, Is_Comp, Is_Mul, ctrl_valid, stall_req, illegal_op};
  endfunction

  function automatic logic [17:0] spec_row(input logic [3:0] op, output logic ok);
    logic [3:0] c;
    logic [1:0] b;
    logic ben, imm, sob, wb, mr, mw, mov, cmp, mul;
    c = EXE_NO_OPERATION; b = COND_NONE; ok = 1'b1;
    {ben, imm, sob, wb, mr, mw, mov, cmp, mul} = 9'd0;
    case (op)
      OP_ADD:  begin c = EXE_ADD; wb = 1'b1; end
      OP_SUB:  begin c = EXE_SUB; wb = 1'b1; end
      OP_AND:  begin c = EXE_AND; wb = 1'b1; end
      OP_SLL:  begin c = EXE_SLL; wb = 1'b1; end
      OP_MUL:  begin c = EXE_MUL; wb = 1'b1; mul = 1'b1; end
      OP_COMP: begin c = EXE_SUB; wb = 1'b1; cmp = 1'b1; end
      OP_ADDI: begin c = EXE_ADD; wb = 1'b1; imm = 1'b1; end
      OP_MOV:  begin imm = 1'b1; mov = 1'b1; end
      OP_LD:   begin c = EXE_ADD; wb = 1'b1; imm = 1'b1; sob = 1'b1; mr = 1'b1; end
      OP_ST:   begin c = EXE_ADD; imm = 1'b1; sob = 1'b1; mw = 1'b1; end
      OP_BNE:  begin imm = 1'b1; b = COND_BNE; ben = 1'b1; sob = 1'b1; end
      OP_JMP:  begin imm = 1'b1; b = COND_JUMP; ben = 1'b1; end
      default: ok = 1'b0;
    endcase
    return {c, b, ben, imm, sob, wb, mr, mw, mov, cmp, mul, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic model_step(input logic r, input logic bt, input logic hz, input logic ov,
                            input logic [3:0] op, output logic [17:0] e);
    logic ok;
    logic [17:0] row;
    e = BUBBLE;
    if (!r) begin
      busy_left = 0;
      flush_left = 0;
    end else if (bt) begin
      busy_left = 0;
      flush_left = FLUSH_DEPTH - 1;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      e[1] = (busy_left > 0);
    end else if (flush_left > 0) begin
      flush_left = flush_left - 1;
    end else if (ov && !hz) begin
      row = spec_row(op, ok);
      if (!ok) begin
        e[0] = 1'b1;
      end else begin
        e = row;
        if (op == OP_MUL && MUL_CYCLES > 1) begin
          busy_left = MUL_CYCLES - 1;
          e[1] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic bt, input logic hz, input logic ov,
                       input logic [3:0] op);
    logic [17:0] e;
    @(negedge clk);
    rst = r; branch_taken = bt; hazard_detected = hz; op_valid = ov; opCode = op;
    model_step(r, bt, hz, ov, op, e);
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    logic [17:0] e;
    logic [17:0] a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a === e) passed++;
        else $display("FAIL bundle cycle=%0d actual=%05h required=%05h", cyc, a, e);
      end
    end
  end

  initial begin : driver
    drive(1'b0, 1'b0, 1'b0, 1'b1, OP_ADD);
    drive(1'b0, 1'b0, 1'b0, 1'b1, OP_ADD);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_ADDI);
    // multiply: three stalled bubbles, then the held opcode decodes
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_MUL);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, OP_ADD);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_ADD);
    // branch in the second busy cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_MUL);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_SUB);
    drive(1'b1, 1'b1, 1'b0, 1'b1, OP_SUB);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_SUB);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_SUB);
    // hazard on ST, then hazard with branch
    drive(1'b1, 1'b0, 1'b1, 1'b1, OP_ST);
    drive(1'b1, 1'b1, 1'b1, 1'b1, OP_ST);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_ST);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_ST);
    // undefined opcode, then LD
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd13);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_LD);
    // reset during multiply
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_MUL);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_AND);
    drive(1'b0, 1'b0, 1'b0, 1'b1, OP_AND);
    drive(1'b1, 1'b0, 1'b0, 1'b1, OP_ADD);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
    end
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) != 0),
            4'($urandom_range(0, 15)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
